// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding types: opcodes, instruction formats and buffer entry layout.
// Used by both the encoder and the decoder side of the core.
package instr_encoder_pkg;

  typedef logic [31:0] word_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;

  typedef enum logic [2:0] {
    FORMAT_NULL,
    FORMAT_R,
    FORMAT_I,
    FORMAT_S,
    FORMAT_B,
    FORMAT_U,
    FORMAT_J
  } format_t;

  typedef struct packed {
    word_t word;
    word_t addr;
    logic  err;
  } entry_t;

  function automatic format_t format_of(input logic [6:0] opcode);
    format_t fmt;
    case (opcode)
      OP_ALU:                    fmt = FORMAT_R;
      OP_ALUI, OP_LOAD, OP_JALR: fmt = FORMAT_I;
      OP_STORE:                  fmt = FORMAT_S;
      OP_BRANCH:                 fmt = FORMAT_B;
      OP_LUI, OP_AUIPC:          fmt = FORMAT_U;
      OP_JAL:                    fmt = FORMAT_J;
      default:                   fmt = FORMAT_NULL;
    endcase
    return fmt;
  endfunction

  // True when value is the sign extension of its low nbits bits.
  function automatic logic fits_signed(input word_t value, input int nbits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= nbits - 1 && value[i] != value[31]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output handshakes of instr_encoder.
// slave is the encoder's view, master the producer/consumer view.
interface instr_encoder_if;
  import instr_encoder_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_opcode;
  logic [4:0] in_rd;
  logic [4:0] in_rs1;
  logic [4:0] in_rs2;
  word_t      in_imm;
  logic [2:0] in_f3;
  logic [6:0] in_f7;

  logic       out_valid;
  logic       out_ready;
  word_t      out_word;
  word_t      out_addr;
  logic       out_err;
  logic       err_seen;

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_imm, in_f3, in_f7, out_ready,
    output in_ready, out_valid, out_word, out_addr, out_err, err_seen
  );

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_imm, in_f3, in_f7, out_ready,
    input  in_ready, out_valid, out_word, out_addr, out_err, err_seen
  );

endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational RV32I field packer: fields -> {word, err}.
// ENCODER_RANGE_CHECK_EN additionally flags immediates the format cannot represent.
module instr_encoder_pack
  import instr_encoder_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [4:0] rd_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  word_t      imm_i,
  input  logic [2:0] f3_i,
  input  logic [6:0] f7_i,
  output word_t      word_o,
  output logic       err_o
);

  format_t fmt;
  logic    range_err;

  assign fmt = format_of(opcode_i);

  always_comb begin
    word_o = {25'b0, opcode_i};
    case (fmt)
      FORMAT_R: word_o = {f7_i, rs2_i, rs1_i, f3_i, rd_i, opcode_i};
      FORMAT_I: word_o = {imm_i[11:0], rs1_i, f3_i, rd_i, opcode_i};
      FORMAT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, f3_i, imm_i[4:0], opcode_i};
      FORMAT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3_i,
                          imm_i[4:1], imm_i[11], opcode_i};
      FORMAT_U: word_o = {imm_i[31:12], rd_i, opcode_i};
      FORMAT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      default:  word_o = {25'b0, opcode_i};
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  // The word is still packed from truncated bits; only the flag reports the loss.
  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FORMAT_I, FORMAT_S: range_err = !fits_signed(imm_i, 12);
      FORMAT_B:           range_err = !fits_signed(imm_i, 13) || imm_i[0];
      FORMAT_J:           range_err = !fits_signed(imm_i, 21) || imm_i[0];
      FORMAT_U:           range_err = |imm_i[11:0];
      default:            range_err = 1'b0;
    endcase
  end
`else
  logic unused_imm0;
  assign unused_imm0 = imm_i[0];
  assign range_err   = 1'b0;
`endif

  assign err_o = (fmt == FORMAT_NULL) || range_err;

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: packs field bundles, tags them with sequential addresses
// and queues them in a 2-entry in-order buffer. Optional macro: ENCODER_RANGE_CHECK_EN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter word_t BASE_ADDR = 32'h0000_0000
)
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  instr_encoder_if.slave bus
);

  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic [1:0] count_q, count_d;
  word_t      addr_q, addr_d;
  logic       err_seen_q, err_seen_d;

  word_t      pack_word;
  logic       pack_err;
  entry_t     new_entry;
  logic       in_ready;
  logic       out_valid;
  logic       push;
  logic       pop;

  instr_encoder_pack u_pack (
    .opcode_i (bus.in_opcode),
    .rd_i     (bus.in_rd),
    .rs1_i    (bus.in_rs1),
    .rs2_i    (bus.in_rs2),
    .imm_i    (bus.in_imm),
    .f3_i     (bus.in_f3),
    .f7_i     (bus.in_f7),
    .word_o   (pack_word),
    .err_o    (pack_err)
  );

  assign new_entry = {pack_word, addr_q, pack_err};

  // Readiness depends only on occupancy so a full buffer never passes through.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    addr_d     = addr_q;
    err_seen_d = err_seen_q;
    if (flush) begin
      count_d    = 2'd0;
      addr_d     = BASE_ADDR;
      err_seen_d = 1'b0;
    end else begin
      if (push) begin
        addr_d     = addr_q + 32'd4;
        err_seen_d = err_seen_q | pack_err;
      end
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = new_entry;
          else                 tail_d = new_entry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          // Popping the last entry leaves head untouched so the outputs hold.
          if (count_q == 2'd2) head_d = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Push needs a free slot, so simultaneous push/pop only happens at occupancy 1.
          head_d = new_entry;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
      addr_q     <= BASE_ADDR;
      err_seen_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      err_seen_q <= err_seen_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_word  = head_q.word;
  assign bus.out_addr  = head_q.addr;
  assign bus.out_err   = head_q.err;
  assign bus.err_seen  = err_seen_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings plus random traffic
// against a queue-based reference model.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam word_t BASE   = 32'h0000_0000;
  localparam word_t BASE_W = 32'hFFFF_FFFC;
`ifdef ENCODER_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic flush   = 1'b0;
  logic flush_w = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  instr_encoder_if bus ();
  instr_encoder_if bus_w ();

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
  );
  instr_encoder #(.BASE_ADDR(BASE_W)) dut_w (
    .clk(clk), .rst_n(rst_n), .flush(flush_w), .bus(bus_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    word_t w;
    word_t a;
    bit    e;
  } exp_t;

  exp_t  q[$];
  word_t addr_m;
  bit    err_m;

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Encoding computed arithmetically from the field layout of each format.
  function automatic void ref_encode(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input word_t imm, input logic [2:0] f3,
                                     input logic [6:0] f7, output word_t w, output bit e);
    int    s;
    bit    fits;
    word_t regs;
    s    = int'(signed'(imm));
    e    = 1'b0;
    fits = 1'b1;
    regs = (32'(rs1) << 15) | (32'(f3) << 12);
    case (op)
      7'h33: w = (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7) | 32'(op);
      7'h13, 7'h03, 7'h67: begin
        w    = ((imm & 32'hFFF) << 20) | regs | (32'(rd) << 7) | 32'(op);
        fits = (s >= -2048) && (s <= 2047);
      end
      7'h23: begin
        w    = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs
             | ((imm & 32'h1F) << 7) | 32'(op);
        fits = (s >= -2048) && (s <= 2047);
      end
      7'h63: begin
        w    = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
             | (32'(rs2) << 20) | regs | (((imm >> 1) & 32'hF) << 8)
             | (((imm >> 11) & 32'h1) << 7) | 32'(op);
        fits = (s >= -4096) && (s <= 4095) && (imm % 2 == 0);
      end
      7'h37, 7'h17: begin
        w    = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
        fits = (imm % 4096 == 0);
      end
      7'h6F: begin
        w    = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
             | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
             | (32'(rd) << 7) | 32'(op);
        fits = (s >= -1048576) && (s <= 1048575) && (imm % 2 == 0);
      end
      default: begin
        w = 32'(op);
        e = 1'b1;
      end
    endcase
    if (RANGE_CHK && !fits) e = 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    addr_m = BASE;
    err_m  = 1'b0;
  endtask

  task automatic check_state();
    check("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    check("err_seen", 32'(bus.err_seen), 32'(err_m));
    if (q.size() != 0) begin
      check("head_word", bus.out_word, q[0].w);
      check("head_addr", bus.out_addr, q[0].a);
      check("head_err", 32'(bus.out_err), 32'(q[0].e));
    end
  endtask

  // Called at a falling edge: checks, drives one cycle, advances the model, returns at next falling edge.
  task automatic step(input bit v, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input word_t imm,
                      input logic [2:0] f3, input logic [6:0] f7, input bit rdy, input bit fl);
    bit    do_push, do_pop;
    word_t w;
    bit    e;
    check_state();
    bus.in_valid  = v;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
    bus.in_f3     = f3;
    bus.in_f7     = f7;
    bus.out_ready = rdy;
    flush         = fl;
    @(posedge clk);
    if (fl) begin
      model_reset();
    end else begin
      do_push = v && (q.size() < 2);
      do_pop  = (q.size() != 0) && rdy;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        ref_encode(op, rd, rs1, rs2, imm, f3, f7, w, e);
        q.push_back('{w: w, a: addr_m, e: e});
        addr_m = addr_m + 32'd4;
        if (e) err_m = 1'b1;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic idle(input bit rdy, input bit fl);
    step(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0, 3'd0, 7'd0, rdy, fl);
  endtask

  logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};

  initial begin
    word_t      imm;
    logic [6:0] op;
    int         sel;

    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0;
    bus.in_rs2 = '0; bus.in_imm = '0; bus.in_f3 = '0; bus.in_f7 = '0; bus.out_ready = 1'b0;
    bus_w.in_valid = 1'b0; bus_w.in_opcode = OP_ALUI; bus_w.in_rd = 5'd1; bus_w.in_rs1 = '0;
    bus_w.in_rs2 = '0; bus_w.in_imm = 32'd5; bus_w.in_f3 = '0; bus_w.in_f7 = '0;
    bus_w.out_ready = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_word", bus.out_word, 32'd0);
    check("rst_out_addr", bus.out_addr, 32'd0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_err_seen", 32'(bus.err_seen), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Address wrap on the high-base instance while the main instance sits idle.
    bus_w.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    bus_w.in_valid = 1'b0;
    check("wrap_full", 32'(bus_w.in_ready), 32'd0);
    check("wrap_addr0", bus_w.out_addr, 32'hFFFF_FFFC);
    bus_w.out_ready = 1'b1;
    @(negedge clk);
    check("wrap_valid1", 32'(bus_w.out_valid), 32'd1);
    check("wrap_addr1", bus_w.out_addr, 32'h0000_0000);
    @(negedge clk);
    check("wrap_empty", 32'(bus_w.out_valid), 32'd0);
    bus_w.out_ready = 1'b0;

    // addi x1,x0,5
    step(1, OP_ALUI, 5'd1, 5'd0, 5'd0, 32'd5, 3'd0, 7'd0, 0, 0);
    check("addi_word", bus.out_word, 32'h0050_0093);
    check("addi_addr", bus.out_addr, BASE);
    check("addi_err", 32'(bus.out_err), 32'd0);
    idle(1, 0);
    idle(0, 1);

    // sw x2,8(x1); beq x1,x2,-4; then a stalled third bundle
    step(1, OP_STORE, 5'd0, 5'd1, 5'd2, 32'd8, 3'd2, 7'd0, 0, 0);
    step(1, OP_BRANCH, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 3'd0, 7'd0, 0, 0);
    check("sw_word", bus.out_word, 32'h0020_A423);
    check("sw_addr", bus.out_addr, BASE);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    step(1, OP_JAL, 5'd1, 5'd0, 5'd0, 32'd2048, 3'd0, 7'd0, 0, 0);
    check("stall_head", bus.out_word, 32'h0020_A423);
    step(1, OP_JAL, 5'd1, 5'd0, 5'd0, 32'd2048, 3'd0, 7'd0, 1, 0);
    check("beq_word", bus.out_word, 32'hFE20_8EE3);
    check("beq_addr", bus.out_addr, BASE + 32'd4);
    step(1, OP_JAL, 5'd1, 5'd0, 5'd0, 32'd2048, 3'd0, 7'd0, 0, 0);
    idle(1, 0);
    check("jal_word", bus.out_word, 32'h0010_00EF);
    check("jal_addr", bus.out_addr, BASE + 32'd8);
    idle(1, 0);

    step(1, OP_LUI, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 3'd0, 7'd0, 0, 0);
    check("lui_word", bus.out_word, 32'h1234_52B7);
    idle(1, 0);

    step(1, OP_ALUI, 5'd1, 5'd0, 5'd0, 32'd2048, 3'd0, 7'd0, 0, 0);
    check("addi2048_word", bus.out_word, 32'h8000_0093);
    check("addi2048_err", 32'(bus.out_err), 32'(RANGE_CHK));
    check("addi2048_seen", 32'(bus.err_seen), 32'(RANGE_CHK));
    idle(1, 0);
    step(1, 7'h7F, 5'd3, 5'd4, 5'd5, 32'h1234, 3'd1, 7'd1, 0, 0);
    check("null_word", bus.out_word, 32'h0000_007F);
    check("null_err", 32'(bus.out_err), 32'd1);
    check("null_seen", 32'(bus.err_seen), 32'd1);
    idle(1, 0);
    idle(0, 1);
    check("flush_seen", 32'(bus.err_seen), 32'd0);

    // Reset mid-stream with two entries buffered
    step(1, OP_ALUI, 5'd1, 5'd0, 5'd0, 32'd5, 3'd0, 7'd0, 0, 0);
    step(1, OP_ALU, 5'd3, 5'd1, 5'd2, 32'd0, 3'd0, 7'h20, 0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_word", bus.out_word, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1, OP_ALUI, 5'd1, 5'd0, 5'd0, 32'd5, 3'd0, 7'd0, 0, 0);
    check("midrst_addr", bus.out_addr, BASE);
    idle(1, 0);

    for (int i = 0; i < 4000; i++) begin
      sel = int'($urandom_range(0, 9));
      op  = (sel == 9) ? 7'($urandom_range(0, 127)) : ops[sel];
      case ($urandom_range(0, 3))
        0:       imm = word_t'(int'($urandom_range(0, 4095)) - 2048);
        1:       imm = $urandom;
        2:       imm = word_t'(int'($urandom_range(0, 2097151)) - 1048576);
        default: imm = $urandom & 32'hFFFF_F000;
      endcase
      step($urandom_range(0, 3) != 0, op, 5'($urandom), 5'($urandom), 5'($urandom), imm,
           3'($urandom), 7'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end
    check_state();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
